// File: rtl/lfsr_gen.sv
// Run-time selectable Fibonacci/Galois LFSR with seed load, zero-seed protection
// and tracking of the sequence period (steps taken to return to the start state).
module lfsr_gen #(
  parameter int          W          = 8,
  parameter logic [W-1:0] POLY       = 8'h1D,
  parameter logic [W-1:0] RESET_SEED = 8'h01
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         galois,
  output logic [W-1:0] q,
  output logic         out_bit,
  output logic         wrap,
  output logic [W-1:0] period,
  output logic         period_vld,
  output logic         seed_fixed
);

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] CNT_MAX = '1;

  // Feedback taps: POLY[i] selects state bit W-1-i.
  function automatic logic [W-1:0] fib_step(input logic [W-1:0] s);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (POLY[i]) fb ^= s[W-1-i];
    end
    return {s[W-2:0], fb};
  endfunction

  function automatic logic [W-1:0] galois_step(input logic [W-1:0] s);
    return {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : '0);
  endfunction

  logic [W-1:0] start;
  logic [W-1:0] cnt;
  logic [W-1:0] step_q;
  logic [W-1:0] cnt_n;
  logic [W-1:0] load_val;
  logic         seed_zero;
  logic         hit_start;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    step_q    = galois ? galois_step(q) : fib_step(q);
    cnt_n     = (cnt == CNT_MAX) ? cnt : cnt + ONE;
    hit_start = (step_q == start);
    seed_zero = (seed == '0);
    load_val  = seed_zero ? ONE : seed;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      q          <= RESET_SEED;
      start      <= RESET_SEED;
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      wrap       <= 1'b0;
      seed_fixed <= 1'b0;
    end else begin
      wrap       <= 1'b0;
      seed_fixed <= 1'b0;
      if (load) begin
        // Load overrides a coincident step, so a wrap on this edge is suppressed.
        q          <= load_val;
        start      <= load_val;
        cnt        <= '0;
        period_vld <= 1'b0;
        seed_fixed <= seed_zero;
      end else if (en) begin
        q <= step_q;
        if (hit_start) begin
          wrap       <= 1'b1;
          period     <= cnt_n;
          period_vld <= 1'b1;
          cnt        <= '0;
        end else begin
          cnt <= cnt_n;
        end
      end
    end
  end

  assign out_bit = q[W-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: a reference model pushes expected outputs to a
// scoreboard as each cycle is driven; they are popped and compared after the edge.
module tb_lfsr_gen;

  logic       clock = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] seed;
  logic       galois;
  logic [7:0] q;
  logic       out_bit;
  logic       wrap;
  logic [7:0] period;
  logic       period_vld;
  logic       seed_fixed;

  lfsr_gen #(.W(8), .POLY(8'h1D), .RESET_SEED(8'h01)) dut (
    .clock      (clock),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .seed       (seed),
    .galois     (galois),
    .q          (q),
    .out_bit    (out_bit),
    .wrap       (wrap),
    .period     (period),
    .period_vld (period_vld),
    .seed_fixed (seed_fixed)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] q;
    logic       wrap;
    logic       vld;
    logic [7:0] per;
    logic       fix;
  } exp_t;

  exp_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_wrap = 0;
  int n_zero = 0;

  logic [7:0] m_q, m_start, m_cnt, m_per;
  logic       m_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // x^8+x^4+x^3+x^2+1 written out as explicit taps.
  function automatic logic [7:0] m_next(input logic [7:0] s, input logic g);
    if (g) return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic model_reset();
    m_q = 8'h01; m_start = 8'h01; m_cnt = 8'h00; m_per = 8'h00; m_vld = 1'b0;
  endtask

  task automatic cyc(input logic l, input logic e, input logic [7:0] sd, input logic g);
    exp_t x, y;
    logic [7:0] nq, cn;
    load = l; en = e; seed = sd; galois = g;
    x.wrap = 1'b0;
    x.fix  = 1'b0;
    if (l) begin
      m_q = (sd == 8'h00) ? 8'h01 : sd;
      m_start = m_q; m_cnt = 8'h00; m_vld = 1'b0;
      x.fix = (sd == 8'h00);
    end else if (e) begin
      nq = m_next(m_q, g);
      cn = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
      m_q = nq;
      if (nq == m_start) begin
        x.wrap = 1'b1; m_per = cn; m_vld = 1'b1; m_cnt = 8'h00;
      end else begin
        m_cnt = cn;
      end
    end
    x.q = m_q; x.vld = m_vld; x.per = m_per;
    sb.push_back(x);
    @(posedge clock);
    #1;
    y = sb.pop_front();
    check("q", 32'(q), 32'(y.q));
    check("out_bit", 32'(out_bit), 32'(y.q[7]));
    check("wrap", 32'(wrap), 32'(y.wrap));
    check("period_vld", 32'(period_vld), 32'(y.vld));
    check("period", 32'(period), 32'(y.per));
    check("seed_fixed", 32'(seed_fixed), 32'(y.fix));
    n_wrap += int'(wrap);
    if (q == 8'h00) n_zero++;
  endtask

  initial begin
    logic [7:0] t2[8];
    logic [7:0] t3[4];
    t2 = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};
    t3 = '{8'h02, 8'h04, 8'h08, 8'h11};

    // 1: reset state, then hold with en low
    rst = 1'b1; en = 1'b0; load = 1'b0; seed = 8'h00; galois = 1'b0;
    model_reset();
    #3;
    check("rst_q", 32'(q), 32'h01);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_vld", 32'(period_vld), 32'h0);
    check("rst_fix", 32'(seed_fixed), 32'h0);
    #9 rst = 1'b0;
    repeat (5) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("idle_q", 32'(q), 32'h01);

    // 2: Galois sequence from 01
    cyc(1'b1, 1'b0, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b1);
      check("t2_q", 32'(q), 32'(t2[i]));
    end

    // 3: Fibonacci sequence from 01
    cyc(1'b1, 1'b0, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      check("t3_q", 32'(q), 32'(t3[i]));
    end

    // 4: full period in both modes
    for (int m = 0; m < 2; m++) begin
      cyc(1'b1, 1'b0, 8'hA5, m[0]);
      n_wrap = 0;
      repeat (255) cyc(1'b0, 1'b1, 8'h00, m[0]);
      check("t4_q", 32'(q), 32'hA5);
      check("t4_wrap", 32'(wrap), 32'h1);
      check("t4_period", 32'(period), 32'd255);
      check("t4_vld", 32'(period_vld), 32'h1);
      check("t4_nwrap", 32'(n_wrap), 32'd1);
      cyc(1'b0, 1'b0, 8'h00, m[0]);
      check("t4_vld_sticky", 32'(period_vld), 32'h1);
    end

    // 6: async reset mid-sequence, between edges
    repeat (20) cyc(1'b0, 1'b1, 8'h00, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("t6_q", 32'(q), 32'h01);
    check("t6_vld", 32'(period_vld), 32'h0);
    check("t6_period", 32'(period), 32'h0);
    check("t6_wrap", 32'(wrap), 32'h0);
    #1 rst = 1'b0;
    // a full period from the reset state proves the step counter was cleared
    n_wrap = 0;
    repeat (255) cyc(1'b0, 1'b1, 8'h00, 1'b1);
    check("t6_period_after", 32'(period), 32'd255);
    check("t6_nwrap", 32'(n_wrap), 32'd1);
    // load beats en in the same cycle
    cyc(1'b1, 1'b1, 8'h3C, 1'b0);
    check("t6_load_wins", 32'(q), 32'h3C);
    check("t6_load_vld", 32'(period_vld), 32'h0);

    // load coinciding with the step that would wrap
    cyc(1'b1, 1'b0, 8'hA5, 1'b0);
    repeat (254) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    check("wl_q", 32'(q), 32'h77);
    check("wl_wrap", 32'(wrap), 32'h0);
    check("wl_vld", 32'(period_vld), 32'h0);

    // mode switches mid-sequence keep start and count
    cyc(1'b1, 1'b0, 8'h5A, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 8'h00, i[2]);

    // 5: zero seed is replaced and flagged for one cycle
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("t5_q", 32'(q), 32'h01);
    check("t5_fix", 32'(seed_fixed), 32'h1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("t5_fix_clear", 32'(seed_fixed), 32'h0);
    n_zero = 0;
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 8'h00, ((i / 37) % 2) == 1);
    check("t5_nonzero", 32'(n_zero), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
